// File: rtl/ahb_dual_master_arbiter.sv
// Two-master to one-slave AHB-Lite arbiter: imem and dmem requests are captured
// into one-entry holds, arbitrated, and reissued on a single slave port.
module ahb_dual_master_arbiter #(
  parameter int XLen        = 64,
  parameter bit ROUND_ROBIN = 1'b1
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic [1:0]      i_htrans,
  input  logic [XLen-1:0] i_haddr,
  input  logic            i_hwrite,
  input  logic [2:0]      i_hsize,
  input  logic [XLen-1:0] i_hwdata,
  output logic [XLen-1:0] i_hrdata,
  output logic            i_hready,
  output logic            i_hresp,
  input  logic [1:0]      d_htrans,
  input  logic [XLen-1:0] d_haddr,
  input  logic            d_hwrite,
  input  logic [2:0]      d_hsize,
  input  logic [XLen-1:0] d_hwdata,
  output logic [XLen-1:0] d_hrdata,
  output logic            d_hready,
  output logic            d_hresp,
  output logic [1:0]      s_htrans,
  output logic [XLen-1:0] s_haddr,
  output logic            s_hwrite,
  output logic [2:0]      s_hsize,
  output logic [2:0]      s_hburst,
  output logic [XLen-1:0] s_hwdata,
  input  logic [XLen-1:0] s_hrdata,
  input  logic            s_hready,
  input  logic            s_hresp
);

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  // Index 0 is the imem master, index 1 is the dmem master throughout.
  logic [1:0]           hold_valid_q, hold_valid_d;
  logic [1:0][XLen-1:0] hold_addr_q, hold_addr_d;
  logic [1:0]           hold_write_q, hold_write_d;
  logic [1:0][2:0]      hold_size_q, hold_size_d;
  logic                 owner_valid_q, owner_valid_d;
  logic                 owner_q, owner_d;
  logic                 rr_ptr_q, rr_ptr_d;
  logic                 lock_q, lock_d;
  logic                 lock_sel_q, lock_sel_d;
  logic [XLen-1:0]      last_addr_q, last_addr_d;
  logic                 last_write_q, last_write_d;
  logic [2:0]           last_size_q, last_size_d;
  logic [1:0][XLen-1:0] rdata_q, rdata_d;

  logic [1:0][XLen-1:0] m_haddr;
  logic [1:0]           m_hwrite;
  logic [1:0][2:0]      m_hsize;
  logic [1:0]           m_hready;
  logic [1:0]           accept;
  logic [1:0]           owns;
  logic                 sel;
  logic                 issue;
  logic                 addr_done;
  logic                 unused_htrans;

  assign m_haddr  = {d_haddr, i_haddr};
  assign m_hwrite = {d_hwrite, i_hwrite};
  assign m_hsize  = {d_hsize, i_hsize};

  assign owns[0] = owner_valid_q & ~owner_q;
  assign owns[1] = owner_valid_q & owner_q;

  // A master is stalled while its hold waits, and follows the slave during its own data phase.
  assign m_hready[0] = owns[0] ? s_hready : ~hold_valid_q[0];
  assign m_hready[1] = owns[1] ? s_hready : ~hold_valid_q[1];

  // SEQ is treated as NONSEQ, so only htrans[1] matters.
  assign accept        = {d_htrans[1], i_htrans[1]} & m_hready;
  assign unused_htrans = ^{i_htrans[0], d_htrans[0]};

  always_comb begin
    if (lock_q) begin
      sel = lock_sel_q;
    end else if (&hold_valid_q) begin
      sel = ROUND_ROBIN ? rr_ptr_q : 1'b1;
    end else begin
      sel = hold_valid_q[1];
    end
  end

  assign issue     = (|hold_valid_q) & (~owner_valid_q | s_hready);
  assign addr_done = issue & s_hready;

  assign s_htrans = issue ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign s_haddr  = issue ? hold_addr_q[sel]  : last_addr_q;
  assign s_hwrite = issue ? hold_write_q[sel] : last_write_q;
  assign s_hsize  = issue ? hold_size_q[sel]  : last_size_q;
  assign s_hburst = 3'b000;
  assign s_hwdata = owns[1] ? d_hwdata : (owns[0] ? i_hwdata : '0);

  assign i_hrdata = owns[0] ? s_hrdata : rdata_q[0];
  assign i_hready = m_hready[0];
  assign i_hresp  = owns[0] & s_hresp;
  assign d_hrdata = owns[1] ? s_hrdata : rdata_q[1];
  assign d_hready = m_hready[1];
  assign d_hresp  = owns[1] & s_hresp;

  always_comb begin
    hold_valid_d  = hold_valid_q;
    hold_addr_d   = hold_addr_q;
    hold_write_d  = hold_write_q;
    hold_size_d   = hold_size_q;
    owner_valid_d = owner_valid_q;
    owner_d       = owner_q;
    rr_ptr_d      = rr_ptr_q;
    lock_d        = issue & ~s_hready;
    lock_sel_d    = sel;
    last_addr_d   = last_addr_q;
    last_write_d  = last_write_q;
    last_size_d   = last_size_q;
    rdata_d       = rdata_q;

    if (addr_done) begin
      hold_valid_d[sel] = 1'b0;
      owner_valid_d     = 1'b1;
      owner_d           = sel;
      rr_ptr_d          = ~sel;
    end else if (s_hready) begin
      owner_valid_d = 1'b0;
    end

    // Remember the last presented address so s_haddr stays put while IDLE.
    if (issue) begin
      last_addr_d  = hold_addr_q[sel];
      last_write_d = hold_write_q[sel];
      last_size_d  = hold_size_q[sel];
    end

    for (int x = 0; x < 2; x++) begin
      if (accept[x]) begin
        hold_valid_d[x] = 1'b1;
        hold_addr_d[x]  = m_haddr[x];
        hold_write_d[x] = m_hwrite[x];
        hold_size_d[x]  = m_hsize[x];
      end
      if (owns[x] && s_hready) begin
        rdata_d[x] = s_hrdata;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hold_valid_q  <= '0;
      hold_addr_q   <= '0;
      hold_write_q  <= '0;
      hold_size_q   <= '0;
      owner_valid_q <= 1'b0;
      owner_q       <= 1'b0;
      rr_ptr_q      <= 1'b0;
      lock_q        <= 1'b0;
      lock_sel_q    <= 1'b0;
      last_addr_q   <= '0;
      last_write_q  <= 1'b0;
      last_size_q   <= '0;
      rdata_q       <= '0;
    end else begin
      hold_valid_q  <= hold_valid_d;
      hold_addr_q   <= hold_addr_d;
      hold_write_q  <= hold_write_d;
      hold_size_q   <= hold_size_d;
      owner_valid_q <= owner_valid_d;
      owner_q       <= owner_d;
      rr_ptr_q      <= rr_ptr_d;
      lock_q        <= lock_d;
      lock_sel_q    <= lock_sel_d;
      last_addr_q   <= last_addr_d;
      last_write_q  <= last_write_d;
      last_size_q   <= last_size_d;
      rdata_q       <= rdata_d;
    end
  end

endmodule

// File: tb/tb_ahb_dual_master_arbiter.sv
// Bench for ahb_dual_master_arbiter: directed cycle checks plus a scoreboard
// of expected slave address phases; a second fixed-priority instance checks dmem-first.
module tb_ahb_dual_master_arbiter;
  localparam int XLen = 64;

  logic            clk = 1'b0;
  logic            resetn;
  logic [1:0]      i_htrans, d_htrans;
  logic [XLen-1:0] i_haddr, d_haddr, i_hwdata, d_hwdata;
  logic            i_hwrite, d_hwrite;
  logic [2:0]      i_hsize, d_hsize;
  logic [XLen-1:0] i_hrdata, d_hrdata;
  logic            i_hready, d_hready, i_hresp, d_hresp;
  logic [1:0]      s_htrans;
  logic [XLen-1:0] s_haddr, s_hwdata, s_hrdata;
  logic            s_hwrite, s_hready, s_hresp;
  logic [2:0]      s_hsize, s_hburst;

  logic [XLen-1:0] fp_i_hrdata, fp_d_hrdata, fp_s_haddr, fp_s_hwdata;
  logic            fp_i_hready, fp_d_hready, fp_i_hresp, fp_d_hresp, fp_s_hwrite;
  logic [1:0]      fp_s_htrans;
  logic [2:0]      fp_s_hsize, fp_s_hburst;

  typedef struct packed {
    logic [XLen-1:0] addr;
    logic            wr;
    logic [2:0]      size;
  } slv_req_t;

  slv_req_t exp_q[$];
  int       check_count = 0;
  int       fail_count  = 0;

  always #5 clk = ~clk;

  ahb_dual_master_arbiter #(.XLen(XLen), .ROUND_ROBIN(1'b1)) dut (
    .clk(clk), .resetn(resetn),
    .i_htrans(i_htrans), .i_haddr(i_haddr), .i_hwrite(i_hwrite), .i_hsize(i_hsize),
    .i_hwdata(i_hwdata), .i_hrdata(i_hrdata), .i_hready(i_hready), .i_hresp(i_hresp),
    .d_htrans(d_htrans), .d_haddr(d_haddr), .d_hwrite(d_hwrite), .d_hsize(d_hsize),
    .d_hwdata(d_hwdata), .d_hrdata(d_hrdata), .d_hready(d_hready), .d_hresp(d_hresp),
    .s_htrans(s_htrans), .s_haddr(s_haddr), .s_hwrite(s_hwrite), .s_hsize(s_hsize),
    .s_hburst(s_hburst), .s_hwdata(s_hwdata), .s_hrdata(s_hrdata), .s_hready(s_hready),
    .s_hresp(s_hresp)
  );

  // Fixed-priority copy behind an always-ready slave; shares the master inputs.
  ahb_dual_master_arbiter #(.XLen(XLen), .ROUND_ROBIN(1'b0)) dut_fp (
    .clk(clk), .resetn(resetn),
    .i_htrans(i_htrans), .i_haddr(i_haddr), .i_hwrite(i_hwrite), .i_hsize(i_hsize),
    .i_hwdata(i_hwdata), .i_hrdata(fp_i_hrdata), .i_hready(fp_i_hready), .i_hresp(fp_i_hresp),
    .d_htrans(d_htrans), .d_haddr(d_haddr), .d_hwrite(d_hwrite), .d_hsize(d_hsize),
    .d_hwdata(d_hwdata), .d_hrdata(fp_d_hrdata), .d_hready(fp_d_hready), .d_hresp(fp_d_hresp),
    .s_htrans(fp_s_htrans), .s_haddr(fp_s_haddr), .s_hwrite(fp_s_hwrite), .s_hsize(fp_s_hsize),
    .s_hburst(fp_s_hburst), .s_hwdata(fp_s_hwdata), .s_hrdata(64'h0), .s_hready(1'b1),
    .s_hresp(1'b0)
  );

  task automatic checkOutput(input string tag, input logic [XLen-1:0] actual,
                             input logic [XLen-1:0] expected);
    check_count++;
    if (actual !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input bit is_d, input logic [XLen-1:0] addr,
                               input logic wr, input logic [2:0] size);
    slv_req_t req;
    req.addr = addr;
    req.wr   = wr;
    req.size = size;
    exp_q.push_back(req);
    if (is_d) begin
      d_htrans = 2'b10; d_haddr = addr; d_hwrite = wr; d_hsize = size;
    end else begin
      i_htrans = 2'b10; i_haddr = addr; i_hwrite = wr; i_hsize = size;
    end
  endtask

  task automatic idleMasters();
    i_htrans = 2'b00;
    d_htrans = 2'b00;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Every completed slave address phase must match the oldest expected request.
  always @(negedge clk) begin
    if (resetn && s_htrans == 2'b10 && s_hready) begin
      checkOutput("sb_pending", XLen'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        slv_req_t req;
        req = exp_q.pop_front();
        checkOutput("sb_addr", s_haddr, req.addr);
        checkOutput("sb_write", XLen'(s_hwrite), XLen'(req.wr));
        checkOutput("sb_size", XLen'(s_hsize), XLen'(req.size));
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    resetn = 1'b0;
    i_htrans = 2'b00; i_haddr = '0; i_hwrite = 1'b0; i_hsize = 3'd0; i_hwdata = '0;
    d_htrans = 2'b00; d_haddr = '0; d_hwrite = 1'b0; d_hsize = 3'd0; d_hwdata = '0;
    s_hrdata = '0; s_hready = 1'b1; s_hresp = 1'b0;

    tick();
    @(negedge clk);
    checkOutput("rst_i_hready", XLen'(i_hready), 64'd1);
    checkOutput("rst_d_hready", XLen'(d_hready), 64'd1);
    checkOutput("rst_i_hresp", XLen'(i_hresp), 64'd0);
    checkOutput("rst_s_htrans", XLen'(s_htrans), 64'd0);
    checkOutput("rst_s_haddr", s_haddr, 64'd0);
    checkOutput("rst_i_hrdata", i_hrdata, 64'd0);
    checkOutput("rst_s_hburst", XLen'(s_hburst), 64'd0);
    tick();
    resetn = 1'b1;

    // Lone imem read.
    tick();
    applyStimulus(1'b0, 64'h100, 1'b0, 3'd2);
    @(negedge clk);
    checkOutput("t1_i_hready_n", XLen'(i_hready), 64'd1);
    tick();
    idleMasters();
    @(negedge clk);
    checkOutput("t1_s_htrans", XLen'(s_htrans), 64'd2);
    checkOutput("t1_s_haddr", s_haddr, 64'h100);
    checkOutput("t1_i_hready_n1", XLen'(i_hready), 64'd0);
    tick();
    s_hrdata = 64'hDEADBEEF;
    @(negedge clk);
    checkOutput("t1_i_hready_n2", XLen'(i_hready), 64'd1);
    checkOutput("t1_i_hrdata", i_hrdata, 64'hDEADBEEF);
    tick();
    s_hrdata = '0;
    @(negedge clk);
    checkOutput("t1_i_hrdata_hold", i_hrdata, 64'hDEADBEEF);

    // Lone dmem write.
    tick();
    applyStimulus(1'b1, 64'h1000_0000, 1'b1, 3'd2);
    tick();
    idleMasters();
    d_hwdata = 64'h41;
    @(negedge clk);
    checkOutput("t2_s_hwrite", XLen'(s_hwrite), 64'd1);
    checkOutput("t2_s_hsize", XLen'(s_hsize), 64'd2);
    checkOutput("t2_d_hready_n1", XLen'(d_hready), 64'd0);
    tick();
    @(negedge clk);
    checkOutput("t2_s_hwdata", s_hwdata, 64'h41);
    checkOutput("t2_d_hready_n2", XLen'(d_hready), 64'd1);
    checkOutput("t2_d_hresp", XLen'(d_hresp), 64'd0);
    tick();
    d_hwdata = '0;

    // Simultaneous requests; reset first so both instances start aligned.
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    for (int k = 0; k < 4; k++) begin
      logic [XLen-1:0] ia, da;
      ia = 64'h200 + 64'(k * 16);
      da = 64'h3000 + 64'(k * 16);
      tick();
      applyStimulus(1'b0, ia, 1'b0, 3'd3);
      applyStimulus(1'b1, da, 1'b0, 3'd3);
      tick();
      idleMasters();
      @(negedge clk);
      checkOutput("t3_rr_first", s_haddr, ia);
      checkOutput("t3_fp_first", fp_s_haddr, da);
      tick();
      @(negedge clk);
      checkOutput("t3_rr_second_htrans", XLen'(s_htrans), 64'd2);
      checkOutput("t3_rr_second", s_haddr, da);
      checkOutput("t3_fp_second", fp_s_haddr, ia);
      checkOutput("t3_i_hready", XLen'(i_hready), 64'd1);
      tick();
      @(negedge clk);
      checkOutput("t3_d_hready", XLen'(d_hready), 64'd1);
    end

    // dmem read with three slave wait states while imem is pending.
    tick();
    applyStimulus(1'b1, 64'h2000, 1'b0, 3'd3);
    tick();
    idleMasters();
    applyStimulus(1'b0, 64'h400, 1'b0, 3'd3);
    @(negedge clk);
    checkOutput("t4_i_accept_ready", XLen'(i_hready), 64'd1);
    tick();
    idleMasters();
    s_hready = 1'b0;
    for (int w = 0; w < 3; w++) begin
      @(negedge clk);
      checkOutput("t4_wait_htrans", XLen'(s_htrans), 64'd0);
      checkOutput("t4_wait_haddr", s_haddr, 64'h2000);
      checkOutput("t4_wait_d_hready", XLen'(d_hready), 64'd0);
      checkOutput("t4_wait_i_hready", XLen'(i_hready), 64'd0);
      if (w < 2) tick();
    end
    tick();
    s_hready = 1'b1;
    s_hrdata = 64'hCAFEF00D;
    @(negedge clk);
    checkOutput("t4_d_hready", XLen'(d_hready), 64'd1);
    checkOutput("t4_d_hrdata", d_hrdata, 64'hCAFEF00D);
    checkOutput("t4_i_htrans", XLen'(s_htrans), 64'd2);
    checkOutput("t4_i_haddr", s_haddr, 64'h400);
    tick();
    s_hrdata = 64'h1234;
    @(negedge clk);
    checkOutput("t4_i_hready", XLen'(i_hready), 64'd1);
    checkOutput("t4_i_hrdata", i_hrdata, 64'h1234);
    checkOutput("t4_d_hrdata_stable", d_hrdata, 64'hCAFEF00D);
    tick();
    s_hrdata = '0;

    // Two-cycle ERROR on an imem fetch.
    tick();
    applyStimulus(1'b0, 64'h500, 1'b0, 3'd2);
    tick();
    idleMasters();
    tick();
    s_hresp  = 1'b1;
    s_hready = 1'b0;
    @(negedge clk);
    checkOutput("t5_i_hresp1", XLen'(i_hresp), 64'd1);
    checkOutput("t5_i_hready1", XLen'(i_hready), 64'd0);
    checkOutput("t5_d_hready1", XLen'(d_hready), 64'd1);
    checkOutput("t5_d_hresp1", XLen'(d_hresp), 64'd0);
    tick();
    s_hready = 1'b1;
    @(negedge clk);
    checkOutput("t5_i_hresp2", XLen'(i_hresp), 64'd1);
    checkOutput("t5_i_hready2", XLen'(i_hready), 64'd1);
    checkOutput("t5_d_hresp2", XLen'(d_hresp), 64'd0);
    tick();
    s_hresp = 1'b0;

    // Asynchronous reset during a dmem data phase.
    tick();
    applyStimulus(1'b1, 64'h7000, 1'b0, 3'd3);
    tick();
    idleMasters();
    tick();
    s_hready = 1'b0;
    @(negedge clk);
    checkOutput("t6_d_hready_busy", XLen'(d_hready), 64'd0);
    #2;
    resetn = 1'b0;
    #1;
    checkOutput("t6_rst_htrans", XLen'(s_htrans), 64'd0);
    checkOutput("t6_rst_d_hready", XLen'(d_hready), 64'd1);
    checkOutput("t6_rst_i_hready", XLen'(i_hready), 64'd1);
    checkOutput("t6_rst_s_haddr", s_haddr, 64'd0);
    tick();
    s_hready = 1'b1;
    resetn   = 1'b1;
    tick();
    applyStimulus(1'b0, 64'h600, 1'b0, 3'd2);
    tick();
    idleMasters();
    @(negedge clk);
    checkOutput("t6_s_htrans", XLen'(s_htrans), 64'd2);
    checkOutput("t6_i_hready_n1", XLen'(i_hready), 64'd0);
    tick();
    s_hrdata = 64'hABCD;
    @(negedge clk);
    checkOutput("t6_i_hready_n2", XLen'(i_hready), 64'd1);
    checkOutput("t6_i_hrdata", i_hrdata, 64'hABCD);
    tick();
    s_hrdata = '0;
    tick();

    checkOutput("sb_drained", XLen'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", check_count, fail_count);
    $finish;
  end

endmodule
